// File: rtl/cellrv32_npu_pkg.sv
// rtl/cellrv32_npu_pkg.sv - shared types and constants for the NPU FIFO reader
package cellrv32_npu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } npu_rd_state_t;

    localparam int NPU_RD_SKID_DEPTH = 2;

endpackage

// File: rtl/cellrv32_npu_skid_buf.sv
// rtl/cellrv32_npu_skid_buf.sv - 2-entry skid buffer with push port, valid/ready pop port and flush
module cellrv32_npu_skid_buf
    import cellrv32_npu_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] pop_data_o,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [NPU_RD_SKID_DEPTH];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         pop;

    assign pop         = pop_valid_o && pop_ready_i;
    assign pop_valid_o = (count_q != 2'd0);
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // The reader never pushes into a full buffer, so no overflow guard is needed here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NPU_RD_SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/cellrv32_npu_fifo_reader.sv
// rtl/cellrv32_npu_fifo_reader.sv - pops a programmed number of FIFO words onto a valid/ready stream
module cellrv32_npu_fifo_reader
    import cellrv32_npu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_nxt_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);

    npu_rd_state_t     state_q, state_d;
    logic [LEN_W-1:0]  pop_rem_q;
    logic [LEN_W-1:0]  out_rem_q;
    logic              nxt_q;
    logic              pop;
    logic              hs;
    logic              flush;
    logic [1:0]        skid_cnt;
    logic [DATA_W:0]   head;
    logic              head_valid;

    assign flush = abort_i && (state_q != IDLE);

    // The empty flag lags a pop by one cycle, so never pop back-to-back.
    assign pop = (state_q == RUN) && !fifo_empty_i && (pop_rem_q != '0) &&
                 !nxt_q && (skid_cnt < 2'd2) && !abort_i;

    assign hs = head_valid && m_ready_i;

    cellrv32_npu_skid_buf #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush),
        .push_i      (pop),
        .push_data_i ({pop_rem_q == LEN_W'(1), fifo_data_i}),
        .pop_data_o  (head),
        .pop_valid_o (head_valid),
        .pop_ready_i (m_ready_i),
        .count_o     (skid_cnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (hs && (out_rem_q == LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pop_rem_q <= '0;
            out_rem_q <= '0;
            nxt_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            nxt_q   <= pop;
            if (state_q == IDLE) begin
                if (start_i && !abort_i) begin
                    pop_rem_q <= len_i;
                    out_rem_q <= len_i;
                end
            end else if (flush) begin
                pop_rem_q <= '0;
                out_rem_q <= '0;
            end else begin
                if (pop) begin
                    pop_rem_q <= pop_rem_q - LEN_W'(1);
                end
                if (hs && (out_rem_q != '0)) begin
                    out_rem_q <= out_rem_q - LEN_W'(1);
                end
            end
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign fifo_nxt_o = pop;
    assign m_valid_o  = head_valid;
    assign m_data_o   = head[DATA_W-1:0];
    assign m_last_o   = head_valid && head[DATA_W];

endmodule

// File: tb/tb_cellrv32_npu_fifo_reader.sv
// tb/tb_cellrv32_npu_fifo_reader.sv - self-checking bench with FIFO environment and transfer-level model
module tb_cellrv32_npu_fifo_reader;

    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_nxt_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;

    always #5 clk = ~clk;

    cellrv32_npu_fifo_reader #(
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_nxt_o   (fifo_nxt_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_last_o     (m_last_o),
        .m_ready_i    (m_ready_i)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Source FIFO environment and transfer-level reference state
    logic [7:0] fq[$];
    logic [7:0] inflight[$];
    logic [7:0] out_log[$];
    bit         rand_push = 0;
    bit         m_run = 0, m_done = 0, prev_nxt = 0;
    int         pops_left = 0, out_left = 0, tot_pops = 0, tot_hs = 0;

    function automatic void fifo_drive();
        fifo_data_i = (fq.size() != 0) ? fq[0] : 8'hEE;
    endfunction

    task automatic cycle();
        bit         e_valid, e_nxt, e_busy, e_done, hs, nxt_act, nd, was_empty;
        logic [7:0] popped;
        @(negedge clk);
        e_busy  = m_run || m_done;
        e_done  = m_done;
        e_valid = m_run && (inflight.size() > 0);
        e_nxt   = m_run && !fifo_empty_i && (pops_left != 0) && !prev_nxt &&
                  (inflight.size() < 2) && !abort_i;
        chk_eq("busy", busy_o, e_busy);
        chk_eq("done", done_o, e_done);
        chk_eq("valid", m_valid_o, e_valid);
        chk_eq("nxt", fifo_nxt_o, e_nxt);
        if (e_valid) begin
            chk_eq("data", m_data_o, inflight[0]);
            chk_eq("last", m_last_o, out_left == 1);
        end
        if (m_valid_o && m_ready_i) out_log.push_back(m_data_o);
        hs      = e_valid && m_ready_i;
        nxt_act = fifo_nxt_o;
        popped  = fifo_data_i;
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_run = 0; m_done = 0; prev_nxt = 0; pops_left = 0; out_left = 0;
            inflight.delete();
        end else if ((m_run || m_done) && abort_i) begin
            m_run = 0; m_done = 0; prev_nxt = 0; pops_left = 0; out_left = 0;
            inflight.delete();
        end else begin
            nd = 0;
            if (m_run) begin
                if (hs) begin
                    void'(inflight.pop_front());
                    out_left--;
                    tot_hs++;
                    if (out_left == 0) begin
                        m_run = 0;
                        nd    = 1;
                    end
                end
                if (e_nxt) begin
                    inflight.push_back(popped);
                    pops_left--;
                    tot_pops++;
                end
            end else if (!m_done && start_i && !abort_i) begin
                if (len_i != 0) begin
                    m_run     = 1;
                    pops_left = int'(len_i);
                    out_left  = int'(len_i);
                end else begin
                    nd = 1;
                end
            end
            m_done   = nd;
            prev_nxt = e_nxt;
        end
        was_empty = (fq.size() == 0);
        if (nxt_act) begin
            chk_eq("pop_nonempty", fq.size() != 0, 1);
            if (fq.size() != 0) void'(fq.pop_front());
        end
        if (rand_push && fq.size() < 16 && $urandom_range(2) == 0) fq.push_back(8'($urandom));
        fifo_empty_i = was_empty;
        fifo_drive();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_run && !m_done) return;
            cycle();
        end
        chk_eq("timeout", m_run || m_done, 0);
    endtask

    task automatic start_xfer(input int len);
        len_i   = LW'(len);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
    endtask

    task automatic load_fifo(input logic [7:0] base, input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
        fifo_drive();
        cycle();
        out_log.delete();
    endtask

    int p0, h0, np;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; abort_i = 1'b0; m_ready_i = 1'b0;
        fifo_empty_i = 1'b1; fifo_data_i = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_busy", busy_o, 0);
        chk_eq("rst_done", done_o, 0);
        chk_eq("rst_nxt", fifo_nxt_o, 0);
        chk_eq("rst_valid", m_valid_o, 0);
        chk_eq("rst_last", m_last_o, 0);
        chk_eq("rst_data", m_data_o, 0);
        rst_i = 1'b0;

        // 1: four preloaded words, ready always high
        load_fifo(8'h11, 4);
        m_ready_i = 1'b1;
        p0 = tot_pops;
        start_xfer(4);
        wait_idle(40);
        cycle();
        chk_eq("t1_pops", tot_pops - p0, 4);
        chk_eq("t1_count", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) chk_eq("t1_word", out_log[i], 8'h11 + 8'(i));

        // 2: downstream stalled for 12 cycles
        load_fifo(8'h21, 6);
        m_ready_i = 1'b0;
        start_xfer(6);
        p0 = tot_pops;
        repeat (12) cycle();
        chk_eq("t2_stall_pops", tot_pops - p0 + 0, 2);
        m_ready_i = 1'b1;
        wait_idle(60);
        chk_eq("t2_count", out_log.size(), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) chk_eq("t2_word", out_log[i], 8'h21 + 8'(i));

        // 3: zero-length transfer
        p0 = tot_pops;
        start_xfer(0);
        chk_eq("t3_done_exp", m_done, 1);
        cycle();
        cycle();
        chk_eq("t3_pops", tot_pops - p0, 0);

        // 4: FIFO empty at start, words arrive later
        load_fifo(8'h00, 0);
        start_xfer(3);
        repeat (5) cycle();
        for (int i = 0; i < 3; i++) fq.push_back(8'h31 + 8'(i));
        fifo_drive();
        wait_idle(40);
        chk_eq("t4_count", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size(); i++) chk_eq("t4_word", out_log[i], 8'h31 + 8'(i));

        // 5: abort after the third handshake, then resume from the FIFO
        load_fifo(8'h40, 10);
        p0 = tot_pops;
        h0 = tot_hs;
        start_xfer(8);
        for (int i = 0; i < 50 && (tot_hs - h0) < 3; i++) cycle();
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        cycle();
        np = tot_pops - p0;
        chk_eq("t5_left", fq.size(), 10 - np);
        if (fq.size() != 0) chk_eq("t5_head", fq[0], 8'h40 + 8'(np));
        out_log.delete();
        start_xfer(2);
        wait_idle(40);
        chk_eq("t5_count", out_log.size(), 2);
        for (int i = 0; i < 2 && i < out_log.size(); i++) chk_eq("t5_word", out_log[i], 8'h40 + 8'(np + i));

        // 6: reset with valid high, then start while busy
        load_fifo(8'h50, 5);
        m_ready_i = 1'b0;
        start_xfer(5);
        for (int i = 0; i < 10 && inflight.size() == 0; i++) cycle();
        start_i = 1'b1; len_i = LW'(9);
        cycle();
        start_i = 1'b0;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        #1;
        chk_eq("t6_valid", m_valid_o, 0);
        chk_eq("t6_data", m_data_o, 0);
        chk_eq("t6_last", m_last_o, 0);
        chk_eq("t6_busy", busy_o, 0);
        load_fifo(8'h60, 6);
        m_ready_i = 1'b1;
        start_xfer(3);
        start_i = 1'b1; len_i = LW'(9);
        repeat (2) cycle();
        start_i = 1'b0;
        wait_idle(40);
        chk_eq("t6_count", out_log.size(), 3);

        // Randomized transfers with random backpressure, FIFO refill and aborts
        rand_push = 1;
        for (int t = 0; t < 25; t++) begin
            start_xfer($urandom_range(9));
            for (int c = 0; c < 300; c++) begin
                if (!m_run && !m_done) break;
                m_ready_i = ($urandom_range(3) != 0);
                abort_i   = ($urandom_range(60) == 0);
                cycle();
                abort_i = 1'b0;
            end
            chk_eq("rand_idle", m_run || m_done, 0);
            cycle();
        end
        rand_push = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
